// File: rtl/seg7_scan_if.sv
// Display-side signal bundle for the two-digit seven-segment scanner.
// master drives the value/controls; slave (the scanner) drives the LED pins.
interface seg7_scan_if;
    logic [7:0] in;
    logic       en;
    logic       blank_lz;
    logic [6:0] seg;
    logic [1:0] an;
    logic       dp;

    modport master (
        output in, en, blank_lz,
        input  seg, an, dp
    );

    modport slave (
        input  in, en, blank_lz,
        output seg, an, dp
    );
endinterface

// File: rtl/seg7_scan.sv
// Two-digit multiplexed seven-segment scanner with blanking gaps, a per-frame
// shadow of the input value and a change indicator on the decimal point.
module seg7_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 4
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);
    localparam int RD   = (REFRESH_DIV < 2) ? 2 : REFRESH_DIV;
    localparam int DC   = (DEAD_CYC < 1) ? 1 : DEAD_CYC;
    localparam int MAXD = (RD > DC) ? RD : DC;
    localparam int CW   = $clog2(MAXD);

    localparam logic [CW-1:0] SHOW_LAST = CW'(RD - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(DC - 1);

    typedef enum logic [1:0] {SHOW0, GAP0, SHOW1, GAP1} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [7:0]    shadow, shadow_d;
    logic          changed, changed_d;
    logic          restart;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          dp_q, dp_d;
    logic          last;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        state_d   = state;
        cnt_d     = cnt + 1'b1;
        shadow_d  = shadow;
        changed_d = changed;
        seg_d     = seg_q;
        an_d      = an_q;
        dp_d      = dp_q;
        last      = (state == SHOW0 || state == SHOW1) ? (cnt == SHOW_LAST)
                                                       : (cnt == GAP_LAST);

        // The first edge after reset behaves like a GAP1->SHOW0 frame start.
        if (restart || (state == GAP1 && last)) begin
            state_d   = SHOW0;
            cnt_d     = '0;
            shadow_d  = bus.in;
            changed_d = (bus.in != shadow);
            seg_d     = hex7(bus.in[3:0]);
            an_d      = bus.en ? 2'b10 : 2'b11;
            dp_d      = !(bus.in != shadow);
        end else if (last) begin
            cnt_d = '0;
            case (state)
                SHOW0: begin
                    state_d = GAP0;
                    seg_d   = '1;
                    an_d    = '1;
                    dp_d    = 1'b1;
                end
                GAP0: begin
                    state_d = SHOW1;
                    seg_d   = hex7(shadow[7:4]);
                    an_d    = (bus.en && !(bus.blank_lz && shadow[7:4] == 4'h0))
                              ? 2'b01 : 2'b11;
                    dp_d    = 1'b1;
                end
                SHOW1: begin
                    state_d = GAP1;
                    seg_d   = '1;
                    an_d    = '1;
                    dp_d    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= SHOW0;
            cnt     <= '0;
            shadow  <= '0;
            changed <= 1'b0;
            restart <= 1'b1;
            seg_q   <= '1;
            an_q    <= '1;
            dp_q    <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            shadow  <= shadow_d;
            changed <= changed_d;
            restart <= 1'b0;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
    assign bus.dp  = dp_q;
endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with an 8-cycle show and 2-cycle blanking dwell.
module tb_seg7_scan;
    logic clk;
    logic rst;
    int   passed;
    int   failed;
    int   total;
    logic [7:0] prev;
    logic [7:0] v;

    localparam logic [6:0] DEC [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_scan_if bus ();

    seg7_scan #(.REFRESH_DIV(8), .DEAD_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic span(input string tag, input int n, input logic [1:0] an,
                        input logic [6:0] seg, input logic dp, input bit seg_care);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".an"}, {6'b0, bus.an}, {6'b0, an});
            if (seg_care)
                chk({tag, ".seg"}, {1'b0, bus.seg}, {1'b0, seg});
            chk({tag, ".dp"}, {7'b0, bus.dp}, {7'b0, dp});
        end
    endtask

    task automatic gap(input string tag);
        span({tag, ".gap"}, 2, 2'b11, 7'h7F, 1'b1, 1'b1);
    endtask

    task automatic frame(input string tag, input logic [1:0] an0, input logic [6:0] lo,
                         input bit lo_care, input logic dp0, input logic [1:0] an1,
                         input logic [6:0] hi, input bit hi_care);
        span({tag, ".s0"}, 8, an0, lo, dp0, lo_care);
        gap({tag, ".g0"});
        span({tag, ".s1"}, 8, an1, hi, 1'b1, hi_care);
        gap({tag, ".g1"});
    endtask

    initial begin
        passed = 0;
        failed = 0;
        total  = 0;
        rst          = 1'b0;
        bus.in       = 8'h3A;
        bus.en       = 1'b1;
        bus.blank_lz = 1'b0;

        @(posedge clk); #1;
        chk("rst.an",  {6'b0, bus.an},  8'h03);
        chk("rst.seg", {1'b0, bus.seg}, 8'h7F);
        chk("rst.dp",  {7'b0, bus.dp},  8'h01);
        @(posedge clk); #1;
        chk("rst2.an", {6'b0, bus.an},  8'h03);
        rst = 1'b1;

        // 3A: A on digit 0 with change flagged, 3 on digit 1
        frame("f1", 2'b10, 7'b0001000, 1, 1'b0, 2'b01, 7'b0110000, 1);

        // Unchanged value, then IN changes mid-SHOW1 without effect
        span("f2.s0", 8, 2'b10, 7'b0001000, 1'b1, 1);
        gap("f2.g0");
        span("f2.s1a", 4, 2'b01, 7'b0110000, 1'b1, 1);
        bus.in = 8'h5C;
        span("f2.s1b", 4, 2'b01, 7'b0110000, 1'b1, 1);
        gap("f2.g1");

        frame("f3", 2'b10, 7'b1000110, 1, 1'b0, 2'b01, 7'b0010010, 1);

        span("f4.s0", 8, 2'b10, 7'b1000110, 1'b1, 1);
        bus.in       = 8'h07;
        bus.blank_lz = 1'b1;
        gap("f4.g0");
        span("f4.s1", 8, 2'b01, 7'b0010010, 1'b1, 1);
        gap("f4.g1");

        // Leading-zero suppression on 07
        span("f5.s0", 8, 2'b10, 7'b1111000, 1'b0, 1);
        gap("f5.g0");
        span("f5.s1", 8, 2'b11, 7'h00, 1'b1, 0);
        bus.blank_lz = 1'b0;
        gap("f5.g1");

        frame("f6", 2'b10, 7'b1111000, 1, 1'b1, 2'b01, 7'b1000000, 1);

        // Display disabled for three whole frames
        bus.en = 1'b0;
        frame("en0a", 2'b11, 7'h00, 0, 1'b1, 2'b11, 7'h00, 0);
        frame("en0b", 2'b11, 7'h00, 0, 1'b1, 2'b11, 7'h00, 0);
        frame("en0c", 2'b11, 7'h00, 0, 1'b1, 2'b11, 7'h00, 0);

        // Re-enable mid-SHOW0: anodes stay off until the next state entry
        span("en1.s0a", 4, 2'b11, 7'h00, 1'b1, 0);
        bus.en = 1'b1;
        span("en1.s0b", 4, 2'b11, 7'h00, 1'b1, 0);
        gap("en1.g0");
        span("en1.s1", 8, 2'b01, 7'b1000000, 1'b1, 1);
        gap("en1.g1");

        // Reset pulse at dwell count 5 of SHOW1
        span("r.s0", 8, 2'b10, 7'b1111000, 1'b1, 1);
        gap("r.g0");
        span("r.s1", 6, 2'b01, 7'b1000000, 1'b1, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rmid.an",  {6'b0, bus.an},  8'h03);
        chk("rmid.seg", {1'b0, bus.seg}, 8'h7F);
        chk("rmid.dp",  {7'b0, bus.dp},  8'h01);
        rst = 1'b1;
        frame("rpost", 2'b10, 7'b1111000, 1, 1'b0, 2'b01, 7'b1000000, 1);

        // Full value sweep, one value per frame
        prev = 8'h07;
        for (int k = 0; k < 256; k++) begin
            v = 8'(k);
            bus.in = v;
            frame("sweep", 2'b10, DEC[v[3:0]], 1, (v != prev) ? 1'b0 : 1'b1,
                  2'b01, DEC[v[7:4]], 1);
            prev = v;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000: CLK cycles each digit is driven; legal range >= 2.
REQ-002 SHALL have parameter DEAD_CYC, default 4: blanking cycles between digits (anti-ghosting); legal range >= 1.
REQ-003 CLK  in  1  single system clock; all logic on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-low.
REQ-005 IN  in  8  count value from upstream binary counter; upper nibble on digit 1, lower on digit 0.
REQ-006 EN  in  1  display enable; 0 forces all anodes off.
REQ-007 BLANK_LZ  in  1  1 = suppress digit 1 when its nibble is 0.
REQ-008 SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 AN  out  2  digit anodes, active-low; AN[0] = low digit, AN[1] = high digit.
REQ-010 DP  out  1  decimal point, active-low; change indicator.

Function
REQ-011 SHALL implement a 4-state scan FSM: SHOW0 -> GAP0 -> SHOW1 -> GAP1 -> SHOW0.
- SHOW states last exactly REFRESH_DIV cycles.
- GAP states last exactly DEAD_CYC cycles.
- One frame = 2*(REFRESH_DIV+DEAD_CYC) cycles.
REQ-012 SHALL use a single dwell counter that clears on every state transition and has width ceil(log2(max(REFRESH_DIV,DEAD_CYC))).
REQ-013 SHALL sample IN into an 8-bit shadow register only on the GAP1->SHOW0 transition; IN changes mid-frame SHALL NOT alter the displayed digits until the next frame.
REQ-014 SHALL register SEG, AN and DP, and update them on the same edge the FSM enters a state, so outputs are glitch-free and constant for the whole state.
REQ-015 In SHOW0, SEG SHALL equal hex decode of shadow[3:0] and AN SHALL be 2'b10.
REQ-016 In SHOW1, SEG SHALL equal hex decode of shadow[7:4] and AN SHALL be 2'b01.
REQ-017 In GAP0 and GAP1, AN SHALL be 2'b11, SEG SHALL be 7'h7F and DP SHALL be 1.
REQ-018 Hex decode SHALL cover all 16 nibble values. Examples: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
REQ-019 When BLANK_LZ=1 and shadow[7:4]=0, AN SHALL stay 2'b11 during SHOW1, while FSM timing is unchanged.
REQ-020 When EN=0, AN SHALL be 2'b11 in every state, while the FSM, dwell counter and shadow sampling keep running. The EN effect takes hold on the next state entry.
REQ-021 At each shadow load, the block SHALL set a change flag to (IN != previous shadow). DP SHALL be 0 during SHOW0 of that frame when the flag is 1, and 1 otherwise.
REQ-022 If a parameter is out of range, the block SHALL clamp it to the minimum legal value.

Reset
REQ-023 RST=0 sampled on a CLK edge SHALL, at that edge, force:
- state SHOW0, dwell counter 0;
- shadow 8'h00, change flag 0;
- AN=2'b11, SEG=7'h7F, DP=1.
REQ-024 Reset asserted mid-state SHALL abort the state immediately, with no completion of the current dwell.
REQ-025 After RST returns to 1, the first rising edge SHALL enter SHOW0 and load shadow from IN. Outputs SHALL reflect that load on that edge, and the change flag SHALL use 8'h00 as the previous value.

Verification (REFRESH_DIV=8, DEAD_CYC=2)
REQ-026 Reset, then IN=8'h3A, EN=1, BLANK_LZ=0 -> AN=10 with SEG=0001000 for 8 cycles; AN=11 for 2 cycles; AN=01 with SEG=0110000 for 8 cycles; AN=11 for 2 cycles. Period is 20 cycles; DP=0 only in the first SHOW0.
REQ-027 IN changes 8'h3A->8'h5C during SHOW1 -> SHOW1 still shows 3. The next SHOW0 shows C (SEG=1000110) with DP=0, and the following frame has DP=1.
REQ-028 IN=8'h07, BLANK_LZ=1 -> AN=11 throughout SHOW1, and SHOW0 shows 7 (SEG=1111000). With BLANK_LZ=0, SHOW1 shows 0 (SEG=1000000).
REQ-029 EN driven 0 for 3 frames -> AN=11 for 60 cycles. On EN=1, display resumes at the next state entry with frame phase unchanged.
REQ-030 RST driven 0 for 1 cycle at dwell count 5 of SHOW1 -> next edge gives AN=11, SEG=7F, DP=1, then a full 8-cycle SHOW0 follows.
REQ-031 Sweep IN over 8'h00..8'hFF, one value per frame -> every frame's SEG codes match REQ-018 decode for both nibbles.
